// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encodings,
// instruction/PC widths, the default reset PC and small PC helpers.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds the TRAP state.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_REQ   = 2'd0,
    IF_FLUSH = 2'd1,
    IF_VALID = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
    , IF_TRAP = 2'd3
`endif
  } if_state_e;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [PC_W-1:0] pc_inc4(input logic [PC_W-1:0] pc);
    return pc + 32'd4;
  endfunction

`ifdef FETCH_MISALIGN_TRAP_EN
  // A target is misaligned when either low address bit is set.
  function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
    return |pc_lsb;
  endfunction
`endif

endpackage

// File: rtl/fetch_unit_buf.sv
// fetch_buf: single-entry holding register for the instruction handed to
// decode, together with its PC and PC+4. Load captures a new entry, pop
// retires it, kill drops it (combinationally masking the valid as well).
module fetch_buf
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_pop,
  input  logic               i_kill,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [PC_W-1:0]    i_pc,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_pc_plus4
);

  logic               r_valid;
  logic [INSTR_W-1:0] r_instr;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_pc_plus4;

  // Capture on load; payload holds until the next load, valid drops on pop/kill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_pc       <= '0;
      r_pc_plus4 <= '0;
    end else if (i_load) begin
      r_valid    <= 1'b1;
      r_instr    <= i_instr;
      r_pc       <= i_pc;
      r_pc_plus4 <= pc_inc4(i_pc);
    end else if (i_pop || i_kill) begin
      r_valid    <= 1'b0;
    end
  end

  assign o_valid    = r_valid & ~i_kill;
  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the architectural PC, requests instruction words over a
// req/ack handshake and hands them to decode over valid/ready. Redirects from
// the branch unit discard buffered or in-flight wrong-path instructions.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (trap on misaligned targets;
// without it the low two target bits are forced to zero).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [PC_W-1:0]    if_pc_plus4
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic               fetch_misaligned
`endif
);

  if_state_e        r_state, w_state_n;
  logic [PC_W-1:0]  r_pc, w_pc_n;       // architectural next-fetch PC
  logic [PC_W-1:0]  r_addr, w_addr_n;   // address of the outstanding request
  logic [PC_W-1:0]  w_rpc;              // redirect target as seen by fetch
  logic [PC_W-1:0]  w_flush_tgt;        // PC to fetch once a stale ack retires
  logic [PC_W-1:0]  w_buf_pc_plus4;
  logic             w_load;
  logic             w_pop;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_rpc = redirect_pc;
`else
  assign w_rpc = redirect_pc & 32'hFFFF_FFFC;
`endif

  // The most recent redirect wins while a stale request drains.
  assign w_flush_tgt = redirect ? w_rpc : r_pc;

  // State, PC and request-address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IF_REQ;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_addr  <= w_addr_n;
    end
  end

  // Next-state, next-PC and buffer control; redirect beats the decode handshake.
  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_addr_n  = r_addr;
    w_load    = 1'b0;
    w_pop     = 1'b0;
    case (r_state)
      IF_REQ: begin
        if (redirect) begin
          w_pc_n = w_rpc;
          if (imem_ack) begin
            // Data for the old path is dropped; new address next cycle.
            w_addr_n  = w_rpc;
            w_state_n = IF_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (pc_misaligned(w_rpc[1:0])) w_state_n = IF_TRAP;
`endif
          end else begin
            // Memory still owes the old word; keep presenting it.
            w_state_n = IF_FLUSH;
          end
        end else if (imem_ack) begin
          w_load    = 1'b1;
          w_state_n = IF_VALID;
        end
      end
      IF_FLUSH: begin
        w_pc_n = w_flush_tgt;
        if (imem_ack) begin
          w_addr_n  = w_flush_tgt;
          w_state_n = IF_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_misaligned(w_flush_tgt[1:0])) w_state_n = IF_TRAP;
`endif
        end
      end
      IF_VALID: begin
        if (redirect) begin
          w_pc_n    = w_rpc;
          w_addr_n  = w_rpc;
          w_state_n = IF_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc_misaligned(w_rpc[1:0])) w_state_n = IF_TRAP;
`endif
        end else if (if_ready) begin
          w_pop     = 1'b1;
          w_pc_n    = w_buf_pc_plus4;
          w_addr_n  = w_buf_pc_plus4;
          w_state_n = IF_REQ;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      IF_TRAP: begin
        if (redirect) begin
          w_pc_n = w_rpc;
          if (!pc_misaligned(w_rpc[1:0])) begin
            w_addr_n  = w_rpc;
            w_state_n = IF_REQ;
          end
        end
      end
`endif
      default: w_state_n = IF_REQ;
    endcase
  end

  assign imem_req  = (r_state == IF_REQ) || (r_state == IF_FLUSH);
  assign imem_addr = r_addr;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_misaligned = (r_state == IF_TRAP);
`endif

  fetch_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_pop      (w_pop),
    .i_kill     (redirect),
    .i_instr    (imem_rdata),
    .i_pc       (r_addr),
    .o_valid    (if_valid),
    .o_instr    (if_instr),
    .o_pc       (if_pc),
    .o_pc_plus4 (w_buf_pc_plus4)
  );

  assign if_pc_plus4 = w_buf_pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by randomized
// redirects, decode backpressure and memory wait states. The reference model
// is the architectural instruction stream: after reset the next instruction
// is at RESET_PC, each accepted instruction advances it by 4, each redirect
// replaces it with the (aligned) target.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_deliv = 0;
  int fixed_dly = 0;   // >= 0: every request waits exactly this long
  int max_dly = 0;     // used when fixed_dly < 0
  bit mem_busy = 1'b0;
  int mem_cnt = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive a redirect for the current cycle and update the expected stream.
  task automatic set_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    exp_q.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
    if (pc[1:0] == 2'b00) exp_q.push_back(pc);
`else
    exp_q.push_back({pc[31:2], 2'b00});
`endif
  endtask

  task automatic wait_valid(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (if_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_valid", {31'b0, found}, 32'h1);
  endtask

  // Instruction memory: ack after a chosen number of wait cycles (0 = same cycle).
  always @(posedge clk) begin
    #2;
    if (rst) begin
      mem_busy = 1'b0;
      imem_ack = 1'b0;
    end else if (imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(max_dly, 0));
      end
      if (mem_cnt == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_cnt--;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
  end

  // Monitor / scoreboard: compares every accepted instruction against the model.
  logic        prev_stall = 1'b0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_instr = 32'h0;
  logic [31:0] prev_pc = 32'h0;
  logic [31:0] prev_addr = 32'h0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_wait  = 1'b0;
    end else begin
      if (redirect) check("kill_on_redirect", {31'b0, if_valid}, 32'h0);
      if (if_valid) check("no_req_while_valid", {31'b0, imem_req}, 32'h0);
      if (prev_stall && if_valid) begin
        check("stall_instr", if_instr, prev_instr);
        check("stall_pc", if_pc, prev_pc);
      end
      if (prev_wait && imem_req) check("addr_stable", imem_addr, prev_addr);
      if (if_valid && if_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_delivery: got pc %h, required no instruction", if_pc);
        end else begin
          e = exp_q.pop_front();
          check("deliv_pc", if_pc, e);
          check("deliv_instr", if_instr, mem_word(e));
          check("deliv_pc_plus4", if_pc_plus4, e + 32'd4);
          exp_q.push_back(e + 32'd4);
          n_deliv++;
        end
      end
      prev_stall = if_valid && !if_ready;
      prev_instr = if_instr;
      prev_pc    = if_pc;
      prev_wait  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bit ack_seen;
    logic [31:0] t;
    exp_q.push_back(32'h0);

    // Reset state
    rst = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h1);
    check("rst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_misaligned", {31'b0, fetch_misaligned}, 32'h0);
`endif

    // Zero-wait fetch right after reset
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("first_req", {31'b0, imem_req}, 32'h1);
    check("first_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("first_valid", {31'b0, if_valid}, 32'h1);
    check("first_pc", if_pc, 32'h0);
    check("first_pc_plus4", if_pc_plus4, 32'h4);
    check("first_instr", if_instr, 32'h0000_0013);

    // Backpressure: buffered instruction holds, no request issued
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'b0, if_valid}, 32'h1);
      check("bp_pc", if_pc, 32'h0);
      check("bp_no_req", {31'b0, imem_req}, 32'h0);
    end
    cyc();
    if_ready = 1'b1;
    @(negedge clk);
    cyc();
    if_ready = 1'b0;
    @(negedge clk);
    check("bp_next_req", {31'b0, imem_req}, 32'h1);
    check("bp_next_addr", imem_addr, 32'h4);
    wait_valid(10);
    check("bp_next_pc", if_pc, 32'h4);

    // Redirect while a request to 0x10 is waiting on memory
    cyc();
    fixed_dly = 3;
    set_redirect(32'h10);
    cyc();
    redirect = 1'b0;
    cyc();
    fixed_dly = 0;
    set_redirect(32'h80);
    cyc();
    redirect = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (imem_ack) begin
        ack_seen = 1'b1;
        break;
      end
    end
    check("stale_ack_seen", {31'b0, ack_seen}, 32'h1);
    @(negedge clk);
    check("flush_next_req", {31'b0, imem_req}, 32'h1);
    check("flush_next_addr", imem_addr, 32'h80);
    wait_valid(10);
    check("flush_pc", if_pc, 32'h80);
    check("flush_instr", if_instr, mem_word(32'h80));

    // Redirect together with the decode handshake
    cyc();
    if_ready = 1'b1;
    set_redirect(32'h200);
    @(negedge clk);
    check("rvh_valid", {31'b0, if_valid}, 32'h0);
    cyc();
    redirect = 1'b0;
    if_ready = 1'b0;
    @(negedge clk);
    check("rvh_req", {31'b0, imem_req}, 32'h1);
    check("rvh_addr", imem_addr, 32'h200);

    // Wrap-around at the top of the address space
    wait_valid(10);
    cyc();
    set_redirect(32'hFFFF_FFFC);
    cyc();
    redirect = 1'b0;
    wait_valid(10);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc_plus4", if_pc_plus4, 32'h0);
    cyc();
    if_ready = 1'b1;
    @(negedge clk);
    cyc();
    if_ready = 1'b0;
    @(negedge clk);
    check("wrap_req", {31'b0, imem_req}, 32'h1);
    check("wrap_addr", imem_addr, 32'h0);
    wait_valid(10);

`ifdef FETCH_MISALIGN_TRAP_EN
    // Misaligned target traps until an aligned redirect
    cyc();
    set_redirect(32'h102);
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("trap_flag", {31'b0, fetch_misaligned}, 32'h1);
      check("trap_no_req", {31'b0, imem_req}, 32'h0);
      check("trap_no_valid", {31'b0, if_valid}, 32'h0);
    end
    cyc();
    set_redirect(32'h104);
    cyc();
    redirect = 1'b0;
    @(negedge clk);
    check("untrap_flag", {31'b0, fetch_misaligned}, 32'h0);
    check("untrap_req", {31'b0, imem_req}, 32'h1);
    check("untrap_addr", imem_addr, 32'h104);
    wait_valid(10);
    check("untrap_pc", if_pc, 32'h104);
`endif

    // Randomized traffic
    fixed_dly = -1;
    max_dly   = 3;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      if_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) begin
        case ($urandom_range(2, 0))
          0:       t = $urandom;
          1:       t = 32'hFFFF_FFF0 + {28'h0, 4'($urandom_range(15, 0))};
          default: t = {24'h0, 8'($urandom_range(255, 0))};
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        t[1:0] = 2'b00;
`endif
        set_redirect(t);
      end else begin
        redirect = 1'b0;
      end
    end
    cyc();
    redirect = 1'b0;
    if_ready = 1'b0;
    @(negedge clk);
    check("random_progress", {31'b0, (n_deliv > 200)}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
